// File: rtl/spi_ram_slave_param.sv
// SPI slave with an on-chip register-array RAM: 2-bit command, then an address or data payload, MSB first.
// Optional burst auto-increment on data commands when SPI_RAM_AUTOINC_EN is defined.
module spi_ram_slave_param #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy
);
  localparam int SHIFT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(SHIFT_W) + 1;
  localparam int DEPTH   = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_TX, HOLD} state_t;

  state_t state_reg, state_next;
  logic armed_reg, cmd_hi_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [SHIFT_W-2:0] rx_reg;
  logic [SHIFT_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_reg;
  logic [ADDR_W-1:0] wr_addr_reg, rd_addr_reg, tx_src_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic cmd_cap, cnt_clr, cnt_inc, rx_shift, tx_shift, tx_load, tx_clr;
  logic wr_addr_ld, rd_addr_ld, wr_addr_step, rd_addr_step, mem_we;
  logic last_addr, last_data;

  assign busy = (state_reg != IDLE);
  assign MISO = (state_reg == RD_TX) ? tx_reg[DATA_W-1] : 1'b0;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    cmd_cap      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    rx_shift     = 1'b0;
    tx_shift     = 1'b0;
    tx_load      = 1'b0;
    tx_clr       = 1'b0;
    tx_src_addr  = rd_addr_reg;
    wr_addr_ld   = 1'b0;
    rd_addr_ld   = 1'b0;
    wr_addr_step = 1'b0;
    rd_addr_step = 1'b0;
    mem_we       = 1'b0;
    rx_next      = {rx_reg, MOSI};
    last_addr    = (cnt_reg == CNT_W'(ADDR_W - 1));
    last_data    = (cnt_reg == CNT_W'(DATA_W - 1));
    // Slave deselect overrides everything, discarding any partial payload.
    if (SS_n) begin
      state_next = IDLE;
      tx_clr     = 1'b1;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (armed_reg) begin
            cmd_cap    = 1'b1;
            state_next = CMD;
          end
        end
        CMD: begin
          cnt_clr = 1'b1;
          case ({cmd_hi_reg, MOSI})
            2'b00:   state_next = WR_ADDR;
            2'b01:   state_next = WR_DATA;
            2'b10:   state_next = RD_ADDR;
            default: begin
              state_next = RD_TX;
              tx_load    = 1'b1;
            end
          endcase
        end
        WR_ADDR, RD_ADDR: begin
          rx_shift = 1'b1;
          cnt_inc  = 1'b1;
          if (last_addr) begin
            state_next = HOLD;
            wr_addr_ld = (state_reg == WR_ADDR);
            rd_addr_ld = (state_reg == RD_ADDR);
          end
        end
        WR_DATA: begin
          rx_shift = 1'b1;
          cnt_inc  = 1'b1;
          if (last_data) begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr_step = 1'b1;
            cnt_clr      = 1'b1;
`else
            state_next = HOLD;
`endif
          end
        end
        RD_TX: begin
          tx_shift = 1'b1;
          cnt_inc  = 1'b1;
          if (last_data) begin
`ifdef SPI_RAM_AUTOINC_EN
            // Prefetch the next word so the output stream has no gap.
            rd_addr_step = 1'b1;
            tx_load      = 1'b1;
            tx_src_addr  = rd_addr_reg + 1'b1;
            cnt_clr      = 1'b1;
`else
            state_next = HOLD;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      armed_reg   <= 1'b0;
      cmd_hi_reg  <= 1'b0;
      cnt_reg     <= '0;
      rx_reg      <= '0;
      tx_reg      <= '0;
      wr_addr_reg <= '0;
      rd_addr_reg <= '0;
    end else begin
      if (SS_n)    armed_reg  <= 1'b1;
      if (cmd_cap) cmd_hi_reg <= MOSI;
      if (cnt_clr)      cnt_reg <= '0;
      else if (cnt_inc) cnt_reg <= cnt_reg + 1'b1;
      if (rx_shift) rx_reg <= rx_next[SHIFT_W-2:0];
      if (tx_clr)        tx_reg <= '0;
      else if (tx_load)  tx_reg <= mem[tx_src_addr];
      else if (tx_shift) tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
      if (wr_addr_ld)        wr_addr_reg <= rx_next[ADDR_W-1:0];
      else if (wr_addr_step) wr_addr_reg <= wr_addr_reg + 1'b1;
      if (rd_addr_ld)        rd_addr_reg <= rx_next[ADDR_W-1:0];
      else if (rd_addr_step) rd_addr_reg <= rd_addr_reg + 1'b1;
    end
  end

  // RAM contents survive reset, so the write port has no reset branch.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_addr_reg] <= rx_next[DATA_W-1:0];
  end
endmodule

// File: tb/tb_spi_ram_slave_param.sv
// Directed bench for spi_ram_slave_param: an 8/8 instance (a) and a 4/16 instance (b) on one clock.
// Inputs change and outputs are sampled on the falling edge.
module tb_spi_ram_slave_param;
  logic clk = 1'b0;
  logic rst_n;
  logic ss_a, mosi_a, miso_a, busy_a;
  logic ss_b, mosi_b, miso_b, busy_b;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_ram_slave_param #(.ADDR_W(8), .DATA_W(8)) dut_a (
    .CLK(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a), .busy(busy_a)
  );

  spi_ram_slave_param #(.ADDR_W(4), .DATA_W(16)) dut_b (
    .CLK(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b), .busy(busy_b)
  );

  task automatic set_ss(input bit sel, input logic v);
    if (sel) ss_b = v; else ss_a = v;
  endtask

  task automatic set_mosi(input bit sel, input logic v);
    if (sel) mosi_b = v; else mosi_a = v;
  endtask

  function automatic logic get_miso(input bit sel);
    return sel ? miso_b : miso_a;
  endfunction

  // One complete frame; rx collects MISO sampled during each payload bit slot.
  task automatic xfer(input bit sel, input logic [1:0] cmd, input logic [63:0] payload,
                      input int nbits, output logic [63:0] rx);
    rx = '0;
    @(negedge clk); set_ss(sel, 1'b0); set_mosi(sel, cmd[1]);
    @(negedge clk); set_mosi(sel, cmd[0]);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      rx = {rx[62:0], get_miso(sel)};
      set_mosi(sel, payload[i]);
    end
    @(negedge clk); set_ss(sel, 1'b1); set_mosi(sel, 1'b0);
    @(negedge clk);
  endtask

  task automatic wr_word(input bit sel, input logic [63:0] addr, input int aw,
                         input logic [63:0] data, input int dw);
    logic [63:0] rx;
    xfer(sel, 2'b00, addr, aw, rx);
    xfer(sel, 2'b01, data, dw, rx);
  endtask

  task automatic rd_word(input bit sel, input logic [63:0] addr, input int aw,
                         input int dw, output logic [63:0] rx);
    logic [63:0] dummy;
    xfer(sel, 2'b10, addr, aw, dummy);
    xfer(sel, 2'b11, 64'h0, dw, rx);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ss_a = 1'b1; ss_b = 1'b1; mosi_a = 1'b0; mosi_b = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (miso_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a: miso=%b busy=%b, required miso=0 busy=0", miso_a, busy_a);
    end
    n_vec++;
    if (miso_b !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b: miso=%b busy=%b, required miso=0 busy=0", miso_b, busy_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released, both slaves idle");
  endtask

  task automatic test_basic;
    logic [63:0] rx;
    wr_word(1'b0, 64'h3C, 8, 64'hA5, 8);
    xfer(1'b0, 2'b10, 64'h3C, 8, rx);
`ifdef SPI_RAM_AUTOINC_EN
    xfer(1'b0, 2'b11, 64'h0, 8, rx);
    n_vec++;
    if (rx[7:0] !== 8'hA5) begin
      n_err++;
      $display("FAIL basic_read: got %h, required a5", rx[7:0]);
    end
`else
    // Two extra slots after the word land in HOLD and must read as zero.
    xfer(1'b0, 2'b11, 64'h0, 10, rx);
    n_vec++;
    if (rx[9:0] !== 10'h294) begin
      n_err++;
      $display("FAIL basic_read: got %b, required 1010010100", rx[9:0]);
    end
`endif
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy_end: got %b, required 0", busy_a);
    end
    $display("basic: wrote a5 @3c, read %h", rx[7:0]);
  endtask

  task automatic test_random;
    logic [7:0] addrs [5] = '{8'h01, 8'h80, 8'h7E, 8'h55, 8'hF0};
    logic [7:0] datas [5] = '{8'h11, 8'hC3, 8'h3F, 8'hAA, 8'h0F};
    logic [63:0] rx;
    for (int i = 0; i < 5; i++) wr_word(1'b0, 64'(addrs[i]), 8, 64'(datas[i]), 8);
    for (int i = 0; i < 5; i++) begin
      rd_word(1'b0, 64'(addrs[i]), 8, 8, rx);
      n_vec++;
      if (rx[7:0] !== datas[i]) begin
        n_err++;
        $display("FAIL inorder_read[%0d]: addr %h got %h, required %h", i, addrs[i], rx[7:0], datas[i]);
      end
      $display("inorder: addr %h read %h", addrs[i], rx[7:0]);
    end
    for (int i = 0; i < 5; i++) begin
      wr_word(1'b0, 64'(addrs[i]), 8, 64'(~datas[i]), 8);
      rd_word(1'b0, 64'(addrs[i]), 8, 8, rx);
      n_vec++;
      if (rx[7:0] !== ~datas[i]) begin
        n_err++;
        $display("FAIL interleaved_read[%0d]: addr %h got %h, required %h", i, addrs[i], rx[7:0], ~datas[i]);
      end
      $display("interleaved: addr %h read %h", addrs[i], rx[7:0]);
    end
  endtask

  task automatic test_abort;
    logic [63:0] rx;
    wr_word(1'b0, 64'h10, 8, 64'h5A, 8);
    xfer(1'b0, 2'b01, 64'hF, 4, rx);
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b, required 0", busy_a);
    end
    // SS_n rises on the edge that would capture the final data bit.
    xfer(1'b0, 2'b01, 64'h7F, 7, rx);
    rd_word(1'b0, 64'h10, 8, 8, rx);
    n_vec++;
    if (rx[7:0] !== 8'h5A) begin
      n_err++;
      $display("FAIL abort_nowrite: mem[10]=%h, required 5a", rx[7:0]);
    end
    $display("abort: mem[10] reads %h after two aborted writes", rx[7:0]);
  endtask

  task automatic test_reset_midframe;
    logic [63:0] rx;
    xfer(1'b0, 2'b10, 64'h3C, 8, rx);
    @(negedge clk); ss_a = 1'b0; mosi_a = 1'b1;
    @(negedge clk); mosi_a = 1'b1;
    @(negedge clk);
    n_vec++;
    if (miso_a !== 1'b1 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_tx: miso=%b busy=%b, required miso=1 busy=1", miso_a, busy_a);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (miso_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reset: miso=%b busy=%b, required miso=0 busy=0", miso_a, busy_a);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL unarmed_no_frame: busy=%b, required 0", busy_a);
    end
    ss_a = 1'b1; mosi_a = 1'b0;
    @(negedge clk);
    rd_word(1'b0, 64'h3C, 8, 8, rx);
    n_vec++;
    if (rx[7:0] !== 8'hA5) begin
      n_err++;
      $display("FAIL post_reset_read: got %h, required a5", rx[7:0]);
    end
    $display("reset mid-frame: re-armed read of 3c gives %h", rx[7:0]);
  endtask

  task automatic test_burst;
    logic [63:0] rx;
`ifdef SPI_RAM_AUTOINC_EN
    xfer(1'b0, 2'b00, 64'hFF, 8, rx);
    xfer(1'b0, 2'b01, 64'h1122, 16, rx);
    rd_word(1'b0, 64'hFF, 8, 16, rx);
    n_vec++;
    if (rx[15:0] !== 16'h1122) begin
      n_err++;
      $display("FAIL burst_read: got %h, required 1122", rx[15:0]);
    end
    rd_word(1'b0, 64'h00, 8, 8, rx);
    n_vec++;
    if (rx[7:0] !== 8'h22) begin
      n_err++;
      $display("FAIL burst_wrap: mem[00]=%h, required 22", rx[7:0]);
    end
    $display("burst: mem[00] reads %h", rx[7:0]);
`else
    wr_word(1'b0, 64'h00, 8, 64'h77, 8);
    xfer(1'b0, 2'b00, 64'hFF, 8, rx);
    xfer(1'b0, 2'b01, 64'h1122, 16, rx);
    rd_word(1'b0, 64'hFF, 8, 8, rx);
    n_vec++;
    if (rx[7:0] !== 8'h11) begin
      n_err++;
      $display("FAIL single_word: mem[ff]=%h, required 11", rx[7:0]);
    end
    rd_word(1'b0, 64'h00, 8, 8, rx);
    n_vec++;
    if (rx[7:0] !== 8'h77) begin
      n_err++;
      $display("FAIL no_autoinc: mem[00]=%h, required 77", rx[7:0]);
    end
    xfer(1'b0, 2'b01, 64'h33, 8, rx);
    rd_word(1'b0, 64'hFF, 8, 8, rx);
    n_vec++;
    if (rx[7:0] !== 8'h33) begin
      n_err++;
      $display("FAIL wr_addr_kept: mem[ff]=%h, required 33", rx[7:0]);
    end
    $display("single-word: mem[ff] reads %h", rx[7:0]);
`endif
  endtask

  task automatic test_wide;
    logic [63:0] rx;
    // Five address bits: the fifth arrives in HOLD and is ignored.
    wr_word(1'b1, 64'h13, 5, 64'hBEEF, 16);
    wr_word(1'b1, 64'h3, 4, 64'h1234, 16);
    rd_word(1'b1, 64'h13, 5, 16, rx);
    n_vec++;
    if (rx[15:0] !== 16'hBEEF) begin
      n_err++;
      $display("FAIL wide_read9: got %h, required beef", rx[15:0]);
    end
    rd_word(1'b1, 64'h3, 4, 16, rx);
    n_vec++;
    if (rx[15:0] !== 16'h1234) begin
      n_err++;
      $display("FAIL wide_read3: got %h, required 1234", rx[15:0]);
    end
    n_vec++;
    if (busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL wide_busy_end: got %b, required 0", busy_b);
    end
    $display("wide: mem[3] reads %h", rx[15:0]);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random;
    test_abort;
    test_reset_midframe;
    test_burst;
    test_wide;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_ram_slave_param.md
Name: spi_ram_slave_param

Overview:
- Parametrised SPI slave with an integrated single-port register-array RAM; successor to the fixed 8-bit SPI slave/RAM wrapper.
- Generalised address and data widths; adds a busy flag, abort-safe writes and a re-arm rule after reset.
- Optional burst auto-increment mode.
- Sits directly on the chip-level SPI pins; CLK is the system clock, which also acts as the SPI bit clock.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W words.
- DATA_W, 8, data word width.

Ports:
- CLK  input  1  system/bit clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; a high level at any rising edge ends the frame.
- MOSI  input  1  serial data in, sampled on rising CLK, MSB first.
- MISO  output  1  serial data out, MSB first, valid only in the RD_TX state.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, MISO=0, busy=0.
  - wr_addr, rd_addr, shift register and bit counter = 0; armed=0.
  - RAM contents are not reset.
- armed: set on the first rising edge with SS_n=1. IDLE accepts a frame only when armed=1, so SS_n held low through reset deassertion starts no frame.
- Frame format: 2-bit command, MSB first, then payload.
  - 00 WR_ADDR: ADDR_W payload bits.
  - 01 WR_DATA: DATA_W payload bits.
  - 10 RD_ADDR: ADDR_W payload bits.
  - 11 RD_DATA: no payload; data is shifted out.
- States: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_TX, HOLD.
- IDLE: on an edge with SS_n=0 and armed=1, capture MOSI as cmd[1] and go to CMD.
- CMD: capture MOSI as cmd[0], clear the bit counter, then branch on cmd:
  - 00 -> WR_ADDR.
  - 01 -> WR_DATA.
  - 10 -> RD_ADDR.
  - 11 -> RD_TX; on the same edge load the tx shift register with mem[rd_addr].
- WR_ADDR / RD_ADDR: shift in ADDR_W bits. On the edge capturing the last bit, load wr_addr / rd_addr and go to HOLD.
- WR_DATA: shift in DATA_W bits. On the edge capturing the last bit, write mem[wr_addr] and go to HOLD.
- RD_TX:
  - MISO = tx_shift[DATA_W-1] (combinational from the register), shifted left on each edge.
  - First bit appears in the cycle after the CMD edge, i.e. 1-cycle turnaround.
  - After DATA_W edges go to HOLD.
- HOLD: MISO=0; extra MOSI bits are ignored; wait for SS_n=1.
- SS_n=1 at any edge in any state: go to IDLE in that edge.
  - Partial payloads are discarded: no RAM write, no address update.
  - The tx shift register is cleared.
- Timing: a complete write frame costs 2+DATA_W edges; a read word appears 1 cycle after the command.
- Simultaneous events:
  - SS_n rising on the edge that would complete a write: the write is discarded (SS_n wins).
  - Reset asserted mid-frame: immediate IDLE, MISO=0.

Optional Feature:
- Macro: SPI_RAM_AUTOINC_EN.
- Defined, WR_DATA:
  - After each complete word, write mem[wr_addr], set wr_addr = wr_addr+1 (wraps at 2**ADDR_W-1 -> 0), stay in WR_DATA and clear the counter.
- Defined, RD_TX:
  - On the edge shifting out the last bit, set rd_addr = rd_addr+1 (with wrap) and reload the tx shift register from mem[rd_addr+1].
  - Output continues with no gap and the state stays RD_TX.
- Both bursts end only on SS_n=1.
- Undefined: single word per frame with HOLD as above; addresses are never modified by data commands.

Test Plan:
- Frames WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA -> MISO shows 1,0,1,0,0,1,0,1 starting 1 cycle after the command; busy=0 after SS_n rises.
- Five random address/data pairs written, then read back in order and interleaved (write/read per pair) -> all reads match the data written.
- WR_DATA 0xFF to address 0x10 with SS_n raised after 4 payload bits -> mem[0x10] keeps its prior value 0x5A; FSM reaches IDLE on that edge.
- rst_n pulsed low mid-RD_TX while SS_n stays low -> MISO=0 immediately; no frame starts until SS_n goes high then low; the next full frame works.
- With SPI_RAM_AUTOINC_EN, WR_ADDR 0xFF then WR_DATA 0x11,0x22 in one frame -> mem[0xFF]=0x11, mem[0x00]=0x22. Burst read from 0xFF returns 0x11 then 0x22 contiguously.
- ADDR_W=4, DATA_W=16: write 0xBEEF to address 0x9 and read it back -> 16 MISO bits equal 0xBEEF. A 5th address bit sent in the frame is ignored in HOLD.
